// File: rtl/simd_register_bank_pkg.sv
// -----------------------------------------------------------------------------
// register_bank_pkg
// Shared sizing constants, types and helpers for the SIMD register bank.
//
// Contents:
//   LANES, NREGS, DATA_W, ADDR_W   default geometry of the bank
//   lane_data_t                    one register word of one lane
//   reg_addr_t                     register address, common to all lanes
//   lane_mask_t                    one bit per lane (enables / masks)
//   addr_in_range()                true when an address maps to a real register
//
// Optional build macro used by the bank: WRITE_BYPASS_EN (see lane_regfile).
// -----------------------------------------------------------------------------
package register_bank_pkg;

  localparam int LANES  = 16;
  localparam int NREGS  = 32;
  localparam int DATA_W = 32;
  localparam int ADDR_W = $clog2(NREGS);

  typedef logic [DATA_W-1:0] lane_data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [LANES-1:0]  lane_mask_t;

  // When the register count fills the whole address space every address is
  // valid; otherwise the top addresses have no backing register.
  function automatic logic addr_in_range(input reg_addr_t addr);
    if (NREGS >= (1 << ADDR_W)) begin
      return 1'b1;
    end
    return (32'(addr) < 32'(NREGS));
  endfunction

endpackage

// File: rtl/simd_register_bank_lane_regfile.sv
// -----------------------------------------------------------------------------
// lane_regfile
// One lane of the SIMD register bank: NREGS x DATA_W storage with one write
// port and two independent, enable-gated combinational read ports.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears every register
//   write_en   write this lane's register at waddr on the next edge
//   waddr      write address
//   wdata      write data for this lane
//   read_en_0  enable for read port 0 (disabled -> output 0)
//   raddr_0    read address, port 0
//   rdata_0    read data, port 0
//   read_en_1  enable for read port 1 (disabled -> output 0)
//   raddr_1    read address, port 1
//   rdata_1    read data, port 1
//
// Build option:
//   WRITE_BYPASS_EN  when defined, a read of the address being written in the
//                    same cycle returns the incoming wdata instead of the
//                    stored (old) value. Undefined: pure storage read.
// -----------------------------------------------------------------------------
module lane_regfile
  import register_bank_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  reg_addr_t  waddr,
  input  lane_data_t wdata,
  input  logic       read_en_0,
  input  reg_addr_t  raddr_0,
  output lane_data_t rdata_0,
  input  logic       read_en_1,
  input  reg_addr_t  raddr_1,
  output lane_data_t rdata_1
);

  lane_data_t regs [NREGS];

  // Storage: reset clears everything at once; a write aimed at an address
  // without a backing register is silently dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en && addr_in_range(waddr)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read port 0. Disabled or out-of-range reads return 0 rather than holding.
  // Forwarding is suppressed during reset so outputs reflect cleared storage.
  always_comb begin
    rdata_0 = '0;
    if (read_en_0 && addr_in_range(raddr_0)) begin
      rdata_0 = regs[raddr_0];
`ifdef WRITE_BYPASS_EN
      if (write_en && !rst && (raddr_0 == waddr)) begin
        rdata_0 = wdata;
      end
`endif
    end
  end

  // Read port 1, identical behaviour to port 0 with its own address/enable.
  always_comb begin
    rdata_1 = '0;
    if (read_en_1 && addr_in_range(raddr_1)) begin
      rdata_1 = regs[raddr_1];
`ifdef WRITE_BYPASS_EN
      if (write_en && !rst && (raddr_1 == waddr)) begin
        rdata_1 = wdata;
      end
`endif
    end
  end

endmodule

// File: rtl/simd_register_bank.sv
// -----------------------------------------------------------------------------
// simd_register_bank
// Per-lane SIMD general-purpose register file. LANES independent lane
// register files share one write address and two read addresses; each lane
// has its own write enable and read enables. Sits between decode/issue
// (addresses, enables), writeback (wdata) and the lane ALUs (rdata).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all registers
//   read_en_0  per-lane enable for read port 0
//   read_en_1  per-lane enable for read port 1
//   raddr_0    read address port 0 (all lanes)
//   raddr_1    read address port 1 (all lanes)
//   write_en   per-lane write enable
//   waddr      write address (all lanes)
//   wdata      write data, lane l at wdata[l*DATA_W +: DATA_W]
//   rdata_0    port 0 read data, same lane packing
//   rdata_1    port 1 read data, same lane packing
//
// Build option:
//   WRITE_BYPASS_EN  same-cycle write-to-read forwarding inside each lane.
// -----------------------------------------------------------------------------
module simd_register_bank
  import register_bank_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  lane_mask_t              read_en_0,
  input  lane_mask_t              read_en_1,
  input  reg_addr_t               raddr_0,
  input  reg_addr_t               raddr_1,
  input  lane_mask_t              write_en,
  input  reg_addr_t               waddr,
  input  logic [LANES*DATA_W-1:0] wdata,
  output logic [LANES*DATA_W-1:0] rdata_0,
  output logic [LANES*DATA_W-1:0] rdata_1
);

  // The top only fans addresses out and slices the packed lane buses.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    lane_regfile u_lane (
      .clk       (clk),
      .rst       (rst),
      .write_en  (write_en[l]),
      .waddr     (waddr),
      .wdata     (wdata[l*DATA_W +: DATA_W]),
      .read_en_0 (read_en_0[l]),
      .raddr_0   (raddr_0),
      .rdata_0   (rdata_0[l*DATA_W +: DATA_W]),
      .read_en_1 (read_en_1[l]),
      .raddr_1   (raddr_1),
      .rdata_1   (rdata_1[l*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_simd_register_bank.sv
// -----------------------------------------------------------------------------
// tb_simd_register_bank
// Self-checking bench for simd_register_bank: a table of directed records,
// a few hand-written multi-cycle sequences, and randomized traffic checked
// against an array model of the register contents.
// Honours WRITE_BYPASS_EN for the expected same-cycle read values.
// -----------------------------------------------------------------------------
module tb_simd_register_bank;
  import register_bank_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  lane_mask_t              read_en_0, read_en_1, write_en;
  reg_addr_t               raddr_0, raddr_1, waddr;
  logic [LANES*DATA_W-1:0] wdata, rdata_0, rdata_1;

  lane_data_t model [LANES][NREGS];
  int errors = 0;
  int checks = 0;

  typedef struct {
    lane_mask_t wmask;
    reg_addr_t  wa;
    lane_data_t wword;
    lane_mask_t ren0;
    reg_addr_t  ra0;
    lane_mask_t ren1;
    reg_addr_t  ra1;
    lane_mask_t emask0;
    lane_data_t ein0;
    lane_data_t eout0;
    lane_mask_t emask1;
    lane_data_t ein1;
    lane_data_t eout1;
  } vec_t;

  vec_t vecs [6];

  simd_register_bank dut (
    .clk       (clk),
    .rst       (rst),
    .read_en_0 (read_en_0),
    .read_en_1 (read_en_1),
    .raddr_0   (raddr_0),
    .raddr_1   (raddr_1),
    .write_en  (write_en),
    .waddr     (waddr),
    .wdata     (wdata),
    .rdata_0   (rdata_0),
    .rdata_1   (rdata_1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int lane,
                             input lane_data_t act, input lane_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s lane %0d: got %h expected %h", name, lane, act, exp);
    end
  endtask

  // Expected read value from the contents model and the current inputs.
  function automatic lane_data_t model_read(input int port, input int lane);
    logic      en;
    reg_addr_t a;
    en = (port == 0) ? read_en_0[lane] : read_en_1[lane];
    a  = (port == 0) ? raddr_0 : raddr_1;
    if (!en || rst) return '0;
`ifdef WRITE_BYPASS_EN
    if (write_en[lane] && a == waddr) return wdata[lane*DATA_W +: DATA_W];
`endif
    return model[lane][a];
  endfunction

  task automatic check_all(input string name);
    for (int l = 0; l < LANES; l++) begin
      checkOutput({name, "_p0"}, l, rdata_0[l*DATA_W +: DATA_W], model_read(0, l));
      checkOutput({name, "_p1"}, l, rdata_1[l*DATA_W +: DATA_W], model_read(1, l));
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < NREGS; r++)
        model[l][r] = '0;
  endtask

  // Called at a negedge: drives one write, takes the edge, records it in the
  // model, and returns at the following negedge with writes disabled.
  task automatic applyStimulus(input lane_mask_t mask, input reg_addr_t a,
                               input logic [LANES*DATA_W-1:0] data);
    write_en = mask;
    waddr    = a;
    wdata    = data;
    @(posedge clk);
    for (int l = 0; l < LANES; l++)
      if (mask[l]) model[l][a] = data[l*DATA_W +: DATA_W];
    @(negedge clk);
    write_en = '0;
  endtask

  function automatic logic [LANES*DATA_W-1:0] random_bus();
    logic [LANES*DATA_W-1:0] b;
    for (int l = 0; l < LANES; l++) b[l*DATA_W +: DATA_W] = $urandom();
    return b;
  endfunction

  initial begin
    rst = 1'b1;
    read_en_0 = '1;
    read_en_1 = '1;
    raddr_0 = 5'd9;
    raddr_1 = 5'd17;
    write_en = '0;
    waddr = '0;
    wdata = '0;
    clear_model();

    // Reset: every enabled lane reads zero.
    #1;
    for (int l = 0; l < LANES; l++) begin
      checkOutput("reset_p0", l, rdata_0[l*DATA_W +: DATA_W], '0);
      checkOutput("reset_p1", l, rdata_1[l*DATA_W +: DATA_W], '0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed records, expectations written as plain constants.
    vecs[0] = '{16'hFFFF, 5'd3, 32'h1111_1111, 16'hFFFF, 5'd3, 16'h0000, 5'd3,
                16'hFFFF, 32'h1111_1111, 32'h0, 16'h0000, 32'h0, 32'h0};
    vecs[1] = '{16'h00F0, 5'd3, 32'hDEAD_BEEF, 16'hFFFF, 5'd3, 16'hFFFF, 5'd3,
                16'h00F0, 32'hDEAD_BEEF, 32'h1111_1111,
                16'h00F0, 32'hDEAD_BEEF, 32'h1111_1111};
    vecs[2] = '{16'h0000, 5'd0, 32'h0, 16'h0001, 5'd3, 16'h0000, 5'd3,
                16'h0001, 32'h1111_1111, 32'h0, 16'h0000, 32'h0, 32'h0};
    vecs[3] = '{16'hFFFF, 5'd1, 32'hAAAA_5555, 16'hFFFF, 5'd1, 16'hFFFF, 5'd3,
                16'hFFFF, 32'hAAAA_5555, 32'h0,
                16'h00F0, 32'hDEAD_BEEF, 32'h1111_1111};
    vecs[4] = '{16'hFFFF, 5'd2, 32'h1234_ABCD, 16'hFFFF, 5'd1, 16'hFFFF, 5'd2,
                16'hFFFF, 32'hAAAA_5555, 32'h0, 16'hFFFF, 32'h1234_ABCD, 32'h0};
    vecs[5] = '{16'h8001, 5'd2, 32'h55AA_55AA, 16'hFFFF, 5'd2, 16'h8000, 5'd2,
                16'h8001, 32'h55AA_55AA, 32'h1234_ABCD,
                16'h8000, 32'h55AA_55AA, 32'h0};

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].wmask, vecs[v].wa, {LANES{vecs[v].wword}});
      read_en_0 = vecs[v].ren0;
      raddr_0   = vecs[v].ra0;
      read_en_1 = vecs[v].ren1;
      raddr_1   = vecs[v].ra1;
      #1;
      for (int l = 0; l < LANES; l++) begin
        checkOutput($sformatf("vec%0d_p0", v), l, rdata_0[l*DATA_W +: DATA_W],
                    vecs[v].emask0[l] ? vecs[v].ein0 : vecs[v].eout0);
        checkOutput($sformatf("vec%0d_p1", v), l, rdata_1[l*DATA_W +: DATA_W],
                    vecs[v].emask1[l] ? vecs[v].ein1 : vecs[v].eout1);
      end
      @(negedge clk);
    end

    // Same-cycle write and read of reg 5 (still zero since reset).
    read_en_0 = '1;
    raddr_0   = 5'd5;
    read_en_1 = 16'h00FF;
    raddr_1   = 5'd5;
    write_en  = '1;
    waddr     = 5'd5;
    wdata     = {LANES{32'hCAFE_F00D}};
    #1;
    for (int l = 0; l < LANES; l++) begin
`ifdef WRITE_BYPASS_EN
      checkOutput("samecyc_p0", l, rdata_0[l*DATA_W +: DATA_W], 32'hCAFE_F00D);
      checkOutput("samecyc_p1", l, rdata_1[l*DATA_W +: DATA_W],
                  (l < 8) ? 32'hCAFE_F00D : 32'h0);
`else
      checkOutput("samecyc_p0", l, rdata_0[l*DATA_W +: DATA_W], 32'h0);
      checkOutput("samecyc_p1", l, rdata_1[l*DATA_W +: DATA_W], 32'h0);
`endif
    end
    @(posedge clk);
    for (int l = 0; l < LANES; l++) model[l][5] = 32'hCAFE_F00D;
    #1;
    write_en = '0;
    #1;
    for (int l = 0; l < LANES; l++)
      checkOutput("after_edge_p0", l, rdata_0[l*DATA_W +: DATA_W], 32'hCAFE_F00D);
    @(negedge clk);

    // Reset during a write: the write is lost and contents clear at once.
    read_en_0 = '1;
    read_en_1 = '1;
    raddr_0   = 5'd1;
    raddr_1   = 5'd2;
    write_en  = '1;
    waddr     = 5'd7;
    wdata     = random_bus();
    rst       = 1'b1;
    #1;
    for (int l = 0; l < LANES; l++) begin
      checkOutput("midrst_p0", l, rdata_0[l*DATA_W +: DATA_W], '0);
      checkOutput("midrst_p1", l, rdata_1[l*DATA_W +: DATA_W], '0);
    end
    @(posedge clk);
    @(negedge clk);
    write_en = '0;
    rst      = 1'b0;
    clear_model();
    raddr_0  = 5'd7;
    raddr_1  = 5'd5;
    #1;
    check_all("postrst");
    @(negedge clk);

    // Full-lane sweep: every address, port 0 alone, port 1 alone, both.
    for (int a = 0; a < NREGS; a++) begin
      for (int it = 0; it < 3; it++) begin
        applyStimulus('1, reg_addr_t'(a), random_bus());
        raddr_0 = reg_addr_t'(a);
        raddr_1 = reg_addr_t'(a);
        read_en_0 = '1; read_en_1 = '0; #1; check_all("sweep_p0only");
        read_en_0 = '0; read_en_1 = '1; #1; check_all("sweep_p1only");
        read_en_0 = '1; read_en_1 = '1; #1; check_all("sweep_both");
        @(negedge clk);
      end
    end

    // Random mixed traffic, checked before each edge (covers forwarding).
    for (int it = 0; it < 300; it++) begin
      write_en  = lane_mask_t'($urandom());
      waddr     = reg_addr_t'($urandom_range(0, NREGS - 1));
      wdata     = random_bus();
      read_en_0 = lane_mask_t'($urandom());
      read_en_1 = lane_mask_t'($urandom());
      raddr_0   = ($urandom_range(0, 3) == 0) ? waddr : reg_addr_t'($urandom());
      raddr_1   = ($urandom_range(0, 3) == 0) ? waddr : reg_addr_t'($urandom());
      #1;
      check_all("random");
      @(posedge clk);
      for (int l = 0; l < LANES; l++)
        if (write_en[l]) model[l][waddr] = wdata[l*DATA_W +: DATA_W];
      @(negedge clk);
    end
    write_en = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
